dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the processor core (port C) and a host loader/readback port (port H). The host preloads operands before a run and reads results after `done`.
- Arbitrates per cycle and drives the data memory's write-enable, address and data-in.
- Registers read data and returns it with a one-cycle `rvalid`.
- Provides a core stall signal, host burst locking and an anti-starvation guarantee for the core.

Parameters:
- AW, 8, memory address width
- DW, 8, data width
- MAX_WAIT, 4, consecutive cycles the core may wait before it is forced to win (range 1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- c_req  in  1  core access request
- c_we  in  1  core write (1) / read (0)
- c_addr  in  AW  core address
- c_wdata  in  DW  core write data
- c_gnt  out  1  core access performed this cycle
- c_stall  out  1  c_req & ~c_gnt
- c_rvalid  out  1  core read data valid (cycle after grant)
- h_req  in  1  host access request
- h_we  in  1  host write/read
- h_addr  in  AW  host address
- h_wdata  in  DW  host write data
- h_lock  in  1  host requests burst ownership
- h_gnt  out  1  host access performed this cycle
- h_rvalid  out  1  host read data valid (cycle after grant)
- rdata  out  DW  registered read data, qualified by c_rvalid/h_rvalid
- mem_wr_en  out  1  to data memory wr_en
- mem_addr  out  AW  to data memory addr
- mem_din  out  DW  to data memory dat_in
- mem_dout  in  DW  from data memory dat_out (combinational read)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ARB, last_winner=H (so the core has first priority), wait_cnt=0.
  - rdata=0, c_rvalid=h_rvalid=0.
  - Grants and mem_wr_en are 0 while reset is asserted.
- Grants are combinational from state plus requests. At most one of c_gnt/h_gnt is high in any cycle.
- Memory-side outputs:
  - mem_addr and mem_din mux from the granted port.
  - mem_wr_en = granted port's we. It is 0 when nothing is granted.
  - mem_addr and mem_din are 0 when idle.
- Read return:
  - On a granted read, rdata <= mem_dout at the clock edge.
  - The matching rvalid pulses high for exactly the next cycle. Latency is 1.
  - A write never raises rvalid, and rdata holds its value.
- State ARB:
  - Only one requester: that requester is granted.
  - Both requesting: round-robin. Grant goes to the port that is not last_winner.
  - last_winner updates on every grant.
  - If h_gnt and h_lock are both high, the next state is HLOCK.
- State HLOCK:
  - The host is granted whenever h_req is high. The core is not granted while h_req is high.
  - If h_req=0 and c_req=1 in HLOCK, the core is granted. The state stays in HLOCK only if h_lock is still 1.
  - Exit to ARB when h_lock=0, sampled at the clock edge.
- Starvation counter (wait_cnt, 4 bits):
  - Increments each cycle c_stall=1, saturating at 15. Clears on c_gnt or ~c_req.
  - When wait_cnt == MAX_WAIT, the core is granted that cycle regardless of state or round-robin.
  - A forced grant in HLOCK does not exit HLOCK.
- Simultaneous forced core grant and host request: the core wins and h_gnt=0. The host keeps h_req asserted and retries; its address and data must be held stable until h_gnt.
- Requesters may change address/we freely while not granted. Only granted-cycle values reach memory.
- Reset asserted mid-burst or mid-read: the state returns to ARB immediately and any pending rvalid is dropped.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - typedef enum logic {ARB, HLOCK} arb_state_t
  - typedef enum logic {PORT_C, PORT_H} port_t
- One natural sub-module, starve_ctr: the saturating wait counter with MAX_WAIT compare, outputting force_c.
- The grant logic, memory mux and read-return register live in dmem_arbiter.

Test Plan:
- Reset/idle: reset=0, then release with no requests → all grants 0, mem_wr_en=0, rdata=0, c_rvalid=h_rvalid=0.
- Single write then read: host writes 0x5A to addr 0x10, then reads addr 0x10 → h_gnt each cycle, mem_wr_en=1 in the write cycle, h_rvalid next cycle with rdata=0x5A.
- Contention round-robin: c_req and h_req both held 4 cycles from reset → grant sequence C,H,C,H. c_stall=1 only in the H-granted cycles.
- Host lock plus starvation (MAX_WAIT=4): host asserts h_lock and h_req continuously, core requests → host granted 4 cycles, core granted on cycle 5 (wait_cnt=4), then host resumes. The state remains HLOCK throughout.
- Lock release: h_lock falls while c_req=1 and h_req=1 → next cycle is round-robin. The core wins because last_winner=H.
- Reset mid-read: a core read is granted, then reset is asserted before the next edge → c_rvalid stays 0 and the state returns to ARB.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter slice.
//   arb_state_t : arbitration mode (open round-robin or host burst lock)
//   port_t      : requester identity, used for round-robin bookkeeping
//   WAIT_W      : width of the core starvation counter
package dmem_arb_pkg;

   typedef enum logic {ARB, HLOCK} arb_state_t;
   typedef enum logic {PORT_C, PORT_H} port_t;

   localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/starve_ctr.sv
// Core starvation counter.
// Counts consecutive cycles in which the core requests but is not granted,
// saturating at all-ones, and asserts force_c once the count reaches MAX_WAIT.
// Ports:
//   clk, reset : clock and asynchronous active-low reset
//   c_req      : core request
//   c_gnt      : core granted this cycle
//   force_c    : core must win this cycle
module starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic c_req,
   input  logic c_gnt,
   output logic force_c
);

   logic [WAIT_W-1:0] wait_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (c_gnt || !c_req) begin
         wait_cnt <= '0;
      end else if (wait_cnt != '1) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign force_c = c_req && (wait_cnt == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the core (C) and the
// host loader/readback port (H).
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata      : core request
//   c_gnt/c_stall/c_rvalid         : core grant, stall, read-data valid
//   h_req/h_we/h_addr/h_wdata      : host request
//   h_lock                         : host burst ownership request
//   h_gnt/h_rvalid                 : host grant, read-data valid
//   rdata                          : registered read data
//   mem_wr_en/mem_addr/mem_din     : to data memory
//   mem_dout                       : from data memory (combinational read)
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW       = 8,
   parameter int unsigned DW       = 8,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_stall,
   output logic          c_rvalid,
   input  logic          h_req,
   input  logic          h_we,
   input  logic [AW-1:0] h_addr,
   input  logic [DW-1:0] h_wdata,
   input  logic          h_lock,
   output logic          h_gnt,
   output logic          h_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   arb_state_t state;
   port_t      last_winner;
   logic       force_c;

   starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
      .clk     (clk),
      .reset   (reset),
      .c_req   (c_req),
      .c_gnt   (c_gnt),
      .force_c (force_c)
   );

   // Grants are gated by reset so nothing reaches memory while it is held.
   always_comb begin
      c_gnt = 1'b0;
      h_gnt = 1'b0;
      if (reset) begin
         if (force_c) begin
            c_gnt = 1'b1;
         end else begin
            unique case (state)
               ARB: begin
                  if (c_req && h_req) begin
                     c_gnt = (last_winner == PORT_H);
                     h_gnt = (last_winner == PORT_C);
                  end else begin
                     c_gnt = c_req;
                     h_gnt = h_req;
                  end
               end
               HLOCK: begin
                  h_gnt = h_req;
                  c_gnt = c_req && !h_req;
               end
            endcase
         end
      end
   end

   assign c_stall = c_req && !c_gnt;

   always_comb begin
      mem_wr_en = 1'b0;
      mem_addr  = '0;
      mem_din   = '0;
      if (c_gnt) begin
         mem_wr_en = c_we;
         mem_addr  = c_addr;
         mem_din   = c_wdata;
      end else if (h_gnt) begin
         mem_wr_en = h_we;
         mem_addr  = h_addr;
         mem_din   = h_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ARB;
         last_winner <= PORT_H;
      end else begin
         if (c_gnt) begin
            last_winner <= PORT_C;
         end else if (h_gnt) begin
            last_winner <= PORT_H;
         end
         unique case (state)
            ARB:   if (h_gnt && h_lock) state <= HLOCK;
            HLOCK: if (!h_lock)         state <= ARB;
         endcase
      end
   end

   // Read return: data captured on a granted read, valid for the next cycle only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata    <= '0;
         c_rvalid <= 1'b0;
         h_rvalid <= 1'b0;
      end else begin
         c_rvalid <= c_gnt && !c_we;
         h_rvalid <= h_gnt && !h_we;
         if ((c_gnt && !c_we) || (h_gnt && !h_we)) begin
            rdata <= mem_dout;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a simple memory model.
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       c_req, c_we, h_req, h_we, h_lock;
   logic [7:0] c_addr, c_wdata, h_addr, h_wdata;
   logic       c_gnt, c_stall, c_rvalid, h_gnt, h_rvalid;
   logic [7:0] rdata;
   logic       mem_wr_en;
   logic [7:0] mem_addr, mem_din, mem_dout;

   logic [7:0] mem [256];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mem_dout = mem[mem_addr];
   always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_din;

   dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .c_req     (c_req),
      .c_we      (c_we),
      .c_addr    (c_addr),
      .c_wdata   (c_wdata),
      .c_gnt     (c_gnt),
      .c_stall   (c_stall),
      .c_rvalid  (c_rvalid),
      .h_req     (h_req),
      .h_we      (h_we),
      .h_addr    (h_addr),
      .h_wdata   (h_wdata),
      .h_lock    (h_lock),
      .h_gnt     (h_gnt),
      .h_rvalid  (h_rvalid),
      .rdata     (rdata),
      .mem_wr_en (mem_wr_en),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
      h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0; h_lock = 0;
   endtask

   task automatic test_reset;
      idle_inputs();
      reset = 0;
      c_req = 1; c_we = 1; h_req = 1; h_we = 1;
      #1;
      checks++;
      if ({c_gnt, h_gnt, mem_wr_en} !== 3'b000) begin
         errors++;
         $display("FAIL reset_grants: got c_gnt=%b h_gnt=%b wr=%b, want 000", c_gnt, h_gnt, mem_wr_en);
      end
      tick(); tick();
      idle_inputs();
      reset = 1;
      tick();
      checks++;
      if ({c_gnt, h_gnt, mem_wr_en, c_rvalid, h_rvalid, c_stall} !== 6'b0 || rdata !== 8'h00 || mem_addr !== 8'h00) begin
         errors++;
         $display("FAIL idle_state: gnt=%b%b wr=%b rv=%b%b stall=%b rdata=%h addr=%h, want all 0",
                  c_gnt, h_gnt, mem_wr_en, c_rvalid, h_rvalid, c_stall, rdata, mem_addr);
      end
   endtask

   task automatic test_single;
      h_req = 1; h_we = 1; h_addr = 8'h10; h_wdata = 8'h5A;
      #1;
      checks++;
      if ({h_gnt, c_gnt, mem_wr_en} !== 3'b101 || mem_addr !== 8'h10 || mem_din !== 8'h5A) begin
         errors++;
         $display("FAIL host_write: h_gnt=%b c_gnt=%b wr=%b addr=%h din=%h, want 1 0 1 10 5a",
                  h_gnt, c_gnt, mem_wr_en, mem_addr, mem_din);
      end
      tick();
      checks++;
      if (h_rvalid !== 1'b0 || rdata !== 8'h00) begin
         errors++;
         $display("FAIL write_no_rvalid: h_rvalid=%b rdata=%h, want 0 00", h_rvalid, rdata);
      end
      h_we = 0; h_wdata = 8'hFF;
      #1;
      checks++;
      if (h_gnt !== 1'b1 || mem_wr_en !== 1'b0 || mem_addr !== 8'h10) begin
         errors++;
         $display("FAIL host_read_gnt: h_gnt=%b wr=%b addr=%h, want 1 0 10", h_gnt, mem_wr_en, mem_addr);
      end
      tick();
      h_req = 0;
      checks++;
      if (h_rvalid !== 1'b1 || c_rvalid !== 1'b0 || rdata !== 8'h5A) begin
         errors++;
         $display("FAIL host_read_data: h_rvalid=%b c_rvalid=%b rdata=%h, want 1 0 5a", h_rvalid, c_rvalid, rdata);
      end
      tick();
      checks++;
      if (h_rvalid !== 1'b0 || rdata !== 8'h5A) begin
         errors++;
         $display("FAIL rvalid_pulse: h_rvalid=%b rdata=%h, want 0 5a", h_rvalid, rdata);
      end
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_c;
      exp_c = 4'b0101;  // cycle 0 in bit 0: C,H,C,H
      reset = 0;
      tick();
      reset = 1;
      c_req = 1; c_we = 1; c_addr = 8'h20; c_wdata = 8'h11;
      h_req = 1; h_we = 1; h_addr = 8'h30; h_wdata = 8'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (c_gnt !== exp_c[i] || h_gnt !== !exp_c[i] || c_stall !== !exp_c[i] ||
             mem_addr !== (exp_c[i] ? 8'h20 : 8'h30)) begin
            errors++;
            $display("FAIL rr_cycle%0d: c_gnt=%b h_gnt=%b stall=%b addr=%h, want c_gnt=%b",
                     i, c_gnt, h_gnt, c_stall, mem_addr, exp_c[i]);
         end
         tick();
      end
      idle_inputs();
      c_req = 1; c_we = 0; c_addr = 8'h30;
      tick();
      c_req = 0;
      checks++;
      if (c_rvalid !== 1'b1 || h_rvalid !== 1'b0 || rdata !== 8'h22) begin
         errors++;
         $display("FAIL core_readback: c_rvalid=%b h_rvalid=%b rdata=%h, want 1 0 22", c_rvalid, h_rvalid, rdata);
      end
      tick();
   endtask

   task automatic test_lock_starve;
      logic exp_core;
      h_req = 1; h_lock = 1; h_we = 1; h_addr = 8'h40; h_wdata = 8'h33;
      #1;
      checks++;
      if (h_gnt !== 1'b1) begin
         errors++;
         $display("FAIL lock_enter: h_gnt=%b, want 1", h_gnt);
      end
      tick();
      c_req = 1; c_we = 0; c_addr = 8'h10;
      // Cycles 1..10: host x4, forced core, host x4 (still locked), forced core.
      for (int i = 1; i <= 10; i++) begin
         exp_core = (i == 5) || (i == 10);
         #1;
         checks++;
         if (c_gnt !== exp_core || h_gnt !== !exp_core || c_stall !== !exp_core ||
             (exp_core && (mem_addr !== 8'h10 || mem_wr_en !== 1'b0))) begin
            errors++;
            $display("FAIL lock_cycle%0d: c_gnt=%b h_gnt=%b stall=%b addr=%h wr=%b, want c_gnt=%b",
                     i, c_gnt, h_gnt, c_stall, mem_addr, mem_wr_en, exp_core);
         end
         tick();
         if (i == 5) begin
            checks++;
            if (c_rvalid !== 1'b1 || rdata !== 8'h5A) begin
               errors++;
               $display("FAIL forced_read: c_rvalid=%b rdata=%h, want 1 5a", c_rvalid, rdata);
            end
         end
      end
   endtask

   task automatic test_lock_release;
      // Still locked; last winner is the core after the forced grant.
      h_lock = 0;
      #1;
      checks++;
      if (h_gnt !== 1'b1 || c_gnt !== 1'b0) begin
         errors++;
         $display("FAIL release_host: h_gnt=%b c_gnt=%b, want 1 0", h_gnt, c_gnt);
      end
      tick();
      #1;
      checks++;
      if (c_gnt !== 1'b1 || h_gnt !== 1'b0) begin
         errors++;
         $display("FAIL release_rr: c_gnt=%b h_gnt=%b, want 1 0", c_gnt, h_gnt);
      end
      tick();
      #1;
      checks++;
      if (h_gnt !== 1'b1 || c_gnt !== 1'b0) begin
         errors++;
         $display("FAIL release_rr2: h_gnt=%b c_gnt=%b, want 1 0", h_gnt, c_gnt);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid_read;
      h_req = 1; h_lock = 1; h_we = 1; h_addr = 8'h50; h_wdata = 8'h44;
      tick();
      h_req = 0;
      c_req = 1; c_we = 0; c_addr = 8'h10;
      #1;
      checks++;
      if (c_gnt !== 1'b1) begin
         errors++;
         $display("FAIL mid_read_gnt: c_gnt=%b, want 1", c_gnt);
      end
      reset = 0;
      #1;
      checks++;
      if (c_gnt !== 1'b0 || mem_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL mid_read_gate: c_gnt=%b wr=%b, want 0 0", c_gnt, mem_wr_en);
      end
      tick();
      checks++;
      if (c_rvalid !== 1'b0 || rdata !== 8'h00) begin
         errors++;
         $display("FAIL mid_read_drop: c_rvalid=%b rdata=%h, want 0 00", c_rvalid, rdata);
      end
      reset = 1;
      h_req = 1;  // in HLOCK the host would win; in ARB after reset the core wins
      #1;
      checks++;
      if (c_gnt !== 1'b1 || h_gnt !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_arb: c_gnt=%b h_gnt=%b, want 1 0", c_gnt, h_gnt);
      end
      tick();
      idle_inputs();
      tick();
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_lock_starve();
      test_lock_release();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
